// File: rtl/master_port.sv
// Serial bus master port: requests the bus, shifts out slave code and address,
// then streams write data out or read data in, with grant/ready timeouts.
module master_port #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rw,
  input  logic [2:0]            slave_id,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  grant,
  input  logic                  slave_ready,
  input  logic                  rdata_bit,
  output logic                  request,
  output logic                  slave_select,
  output logic                  bus_mode,
  output logic                  addr_bit,
  output logic                  wdata_bit,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int MAX_AD  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int MAX_CNT = (GRANT_TIMEOUT > MAX_AD) ? GRANT_TIMEOUT : MAX_AD;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int AIW     = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
  localparam int DIW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] SEL_LAST  = CW'(2);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE, REQ, SEL, ADDR, WAIT_RDY, WRITE, READ, FIN
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [2:0]            sid_q, sid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsh_q, rsh_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  request_q, request_d;
  logic                  slave_select_q, slave_select_d;
  logic                  bus_mode_q, bus_mode_d;
  logic                  addr_bit_q, addr_bit_d;
  logic                  wdata_bit_q, wdata_bit_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  always_comb begin
    // NOTE: every *_d starts from a default so no path through this block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    sid_d   = sid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsh_d   = rsh_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // The arbiter only recognises slave codes with a leading 1.
          if (slave_id[0]) begin
            rw_d    = rw;
            sid_d   = slave_id;
            addr_d  = addr;
            wdata_d = wdata;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (grant) begin
          cnt_d   = '0;
          state_d = SEL;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SEL: begin
        if (cnt_q == SEL_LAST) begin
          cnt_d   = '0;
          state_d = ADDR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_RDY;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_RDY: begin
        if (slave_ready) begin
          cnt_d   = '0;
          state_d = rw_q ? WRITE : READ;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WRITE: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      READ: begin
        rsh_d = {rdata_bit, rsh_q[DATA_WIDTH-1:1]};
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          rdata_d = rsh_d;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Losing the grant after it was given aborts the transfer and discards any read.
    if ((state_q inside {SEL, ADDR, WAIT_RDY, WRITE, READ}) && !grant) begin
      cnt_d   = '0;
      rdata_d = rdata_q;
      err_d   = 1'b1;
      state_d = IDLE;
    end

    request_d      = state_d inside {REQ, SEL, ADDR, WAIT_RDY, WRITE, READ};
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == FIN);
    bus_mode_d     = request_d && rw_d;
    slave_select_d = (state_d == SEL)   && sid_d[cnt_d[1:0]];
    addr_bit_d     = (state_d == ADDR)  && addr_d[cnt_d[AIW-1:0]];
    wdata_bit_d    = (state_d == WRITE) && wdata_d[cnt_d[DIW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rw_q           <= 1'b0;
      sid_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rsh_q          <= '0;
      rdata_q        <= '0;
      request_q      <= 1'b0;
      slave_select_q <= 1'b0;
      bus_mode_q     <= 1'b0;
      addr_bit_q     <= 1'b0;
      wdata_bit_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rw_q           <= rw_d;
      sid_q          <= sid_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rsh_q          <= rsh_d;
      rdata_q        <= rdata_d;
      request_q      <= request_d;
      slave_select_q <= slave_select_d;
      bus_mode_q     <= bus_mode_d;
      addr_bit_q     <= addr_bit_d;
      wdata_bit_q    <= wdata_bit_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign request      = request_q;
  assign slave_select = slave_select_q;
  assign bus_mode     = bus_mode_q;
  assign addr_bit     = addr_bit_q;
  assign wdata_bit    = wdata_bit_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;

endmodule

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, width of slave address shifted serially LSB first.
REQ-002 Parameter DATA_WIDTH, default 8, width of read/write data shifted serially LSB first.
REQ-003 Parameter GRANT_TIMEOUT, default 16, maximum cycles waited for grant or slave_ready before abort.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; launches a transaction; sampled only in IDLE.
REQ-007 rw  input  1  1 = write, 0 = read; captured with start.
REQ-008 slave_id  input  3  target slave code; captured with start.
REQ-009 addr  input  ADDR_WIDTH  target address; captured with start.
REQ-010 wdata  input  DATA_WIDTH  write data; captured with start.
REQ-011 grant  input  1  bus grant from arbiter for this master.
REQ-012 slave_ready  input  1  addressed slave ready to stream read data or accept write data.
REQ-013 rdata_bit  input  1  serial read data from slave, LSB first.
REQ-014 request  output  1  bus request to arbiter.
REQ-015 slave_select  output  1  serial slave code to arbiter, LSB first.
REQ-016 bus_mode  output  1  registered copy of rw, valid while request high.
REQ-017 addr_bit  output  1  serial address, LSB first.
REQ-018 wdata_bit  output  1  serial write data, LSB first.
REQ-019 busy  output  1  high from accepted start until return to IDLE.
REQ-020 done  output  1  one-cycle pulse at successful completion.
REQ-021 err  output  1  one-cycle pulse at abort (bad slave_id or timeout).
REQ-022 rdata  output  DATA_WIDTH  assembled read data; updated only on successful read.

Function
REQ-023 States SHALL be IDLE, REQ, SEL, ADDR, WAIT_RDY, WRITE, READ, FIN; one shared bit/timeout counter.
REQ-024 IDLE: start=1 with slave_id[0]=1 -> capture rw/slave_id/addr/wdata, busy=1, go REQ next cycle.
REQ-025 IDLE: start=1 with slave_id[0]=0 -> err pulse next cycle, no request, stay IDLE (arbiter requires leading 1).
REQ-026 REQ: request=1; counter increments each cycle grant=0; grant=1 -> clear counter, go SEL.
REQ-027 REQ: counter reaching GRANT_TIMEOUT with grant=0 -> drop request, err pulse, go IDLE.
REQ-028 SEL: exactly 3 cycles; slave_select drives slave_id[0], [1], [2] in successive cycles; slave_select=0 outside SEL.
REQ-029 ADDR: exactly ADDR_WIDTH cycles; addr_bit drives addr[0] upward; addr_bit=0 outside ADDR.
REQ-030 ADDR completion -> WAIT_RDY; WAIT_RDY waits for slave_ready=1 under same GRANT_TIMEOUT rule (timeout -> err, IDLE).
REQ-031 WAIT_RDY with slave_ready=1: rw=1 -> WRITE, rw=0 -> READ.
REQ-032 WRITE: DATA_WIDTH cycles, wdata_bit drives wdata[0] upward, then FIN.
REQ-033 READ: DATA_WIDTH cycles, rdata_bit sampled each cycle into shift register LSB first; rdata loaded at FIN.
REQ-034 FIN: one cycle; done=1, request=0, busy=0 next cycle, return IDLE.
REQ-035 request SHALL stay high continuously REQ through last data cycle; grant dropping mid-transfer -> err pulse, abort to IDLE.
REQ-036 start while busy=1 SHALL be ignored; captured fields stable for whole transaction.
REQ-037 done and err SHALL never assert in the same cycle.

Reset
REQ-038 reset=1 SHALL immediately force IDLE; request, slave_select, addr_bit, wdata_bit, bus_mode, busy, done, err = 0; rdata = 0; counter = 0.
REQ-039 reset mid-transaction SHALL abort without done or err pulse; first start after release behaves as fresh.

Verification
REQ-040 Write: start, rw=1, slave_id=3'b101, addr=12'h0A5, wdata=8'h3C, grant 2 cycles later -> slave_select 1,0,1; addr_bit stream of 0x0A5 LSB first; after slave_ready wdata_bit stream of 0x3C; done pulse; request low.
REQ-041 Read: rw=0, slave_id=3'b011, slave drives 8'hA7 LSB first -> rdata=8'hA7 at done, err=0.
REQ-042 Grant never arrives -> request high exactly GRANT_TIMEOUT cycles, then err pulse, busy=0, no slave_select activity.
REQ-043 slave_id=3'b010 -> err pulse, request never asserts, busy stays 0.
REQ-044 reset asserted during ADDR -> outputs zero same cycle, no done/err; subsequent write completes normally.
REQ-045 grant deasserted during WRITE -> err pulse, request drops, rdata unchanged.
